// File: rtl/scroll_display_driver_pkg.sv
// scroll_display_driver_pkg -- segment font constants, sizing helper and parameter checks.
// Rev 1.0
`default_nettype none

package scroll_display_driver_pkg;

  // Active-low segment patterns, bit order {a,b,c,d,e,f,g}
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b1100000;
  localparam logic [6:0] SEG_C     = 7'b0110001;
  localparam logic [6:0] SEG_D     = 7'b1000010;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_F     = 7'b0111000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Ceiling log2, never below 1 so the result can always size a vector
  function automatic int clog2(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 31; i++) begin
      if ((longint'(1) << i) < longint'(value)) result = i + 1;
    end
    return result;
  endfunction

  function automatic bit params_ok(input int num_digits, input int msg_len,
                                   input int refresh_div, input int debounce_cyc,
                                   input int auto_div);
    return (num_digits >= 1) && (msg_len >= num_digits) && (refresh_div >= 2) &&
           (debounce_cyc >= 1) && (auto_div >= 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/scroll_display_driver_font.sv
// seg7_font -- combinational hex digit to active-low 7-segment decoder.
// Rev 1.0
`default_nettype none

module seg7_font
  import scroll_display_driver_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (value)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/scroll_display_driver.sv
// scroll_display_driver -- multiplexed N-digit 7-segment driver with a scrolling message window.
// Rev 1.0
`default_nettype none

module scroll_display_driver
  import scroll_display_driver_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int MSG_LEN      = 16,
  parameter int REFRESH_DIV  = 16,
  parameter int DEBOUNCE_CYC = 4,
  parameter int AUTO_DIV     = 1024
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        button,
  input  logic                        auto_en,
  input  logic                        dir,
  input  logic [4*MSG_LEN-1:0]        msg,
  output logic [NUM_DIGITS-1:0]       an,
  output logic [6:0]                  seg,
  output logic                        dp,
  output logic [clog2(MSG_LEN)-1:0]   pos
);

  localparam int POS_W  = clog2(MSG_LEN);
  localparam int S_W    = clog2(REFRESH_DIV);
  localparam int D_W    = clog2(NUM_DIGITS);
  localparam int DB_W   = clog2(DEBOUNCE_CYC + 1);
  localparam int AUTO_W = clog2(AUTO_DIV);
  localparam int IDX_W  = clog2(2 * MSG_LEN);

  if (!params_ok(NUM_DIGITS, MSG_LEN, REFRESH_DIV, DEBOUNCE_CYC, AUTO_DIV)) begin : g_param_check
    $error("scroll_display_driver: illegal parameter combination");
  end

  logic              sync_meta;
  logic              sync_level;
  logic              db_level;
  logic              db_level_q;
  logic [DB_W-1:0]   db_cnt;
  logic [AUTO_W-1:0] auto_cnt;
  logic [S_W-1:0]    slot;
  logic [D_W-1:0]    digit;
  logic              btn_step;
  logic              auto_step;
  logic              step;
  logic [IDX_W-1:0]  char_idx;
  logic [3:0]        char_val;
  logic [6:0]        font_seg;

  // Button: two-flop synchroniser, then a level debouncer
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_meta  <= 1'b0;
      sync_level <= 1'b0;
      db_level   <= 1'b0;
      db_level_q <= 1'b0;
      db_cnt     <= '0;
    end else begin
      sync_meta  <= button;
      sync_level <= sync_meta;
      db_level_q <= db_level;
      if (sync_level == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_W'(DEBOUNCE_CYC - 1)) begin
        db_level <= ~db_level;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign btn_step = db_level & ~db_level_q;

  always_ff @(posedge clk) begin
    if (reset || !auto_en) begin
      auto_cnt <= '0;
    end else if (auto_cnt == AUTO_W'(AUTO_DIV - 1)) begin
      auto_cnt <= '0;
    end else begin
      auto_cnt <= auto_cnt + 1'b1;
    end
  end

  assign auto_step = auto_en && (auto_cnt == AUTO_W'(AUTO_DIV - 1));
  // Coincident button and auto steps merge into a single advance
  assign step      = btn_step | auto_step;

  always_ff @(posedge clk) begin
    if (reset) begin
      pos <= '0;
    end else if (step) begin
      if (dir) begin
        pos <= (pos == '0) ? POS_W'(MSG_LEN - 1) : pos - 1'b1;
      end else begin
        pos <= (pos == POS_W'(MSG_LEN - 1)) ? '0 : pos + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot  <= '0;
      digit <= '0;
    end else if (slot == S_W'(REFRESH_DIV - 1)) begin
      slot  <= '0;
      digit <= (digit == D_W'(NUM_DIGITS - 1)) ? '0 : digit + 1'b1;
    end else begin
      slot <= slot + 1'b1;
    end
  end

  // Sum stays below 2*MSG_LEN, so one conditional subtract is the modulo
  always_comb begin
    char_idx = IDX_W'(pos) + IDX_W'(NUM_DIGITS - 1) - IDX_W'(digit);
    if (char_idx >= IDX_W'(MSG_LEN)) char_idx = char_idx - IDX_W'(MSG_LEN);
  end

  always_comb begin
    char_val = 4'h0;
    for (int i = 0; i < MSG_LEN; i++) begin
      if (char_idx == IDX_W'(i)) char_val = msg[4*i +: 4];
    end
  end

  seg7_font u_font (
    .value (char_val),
    .seg   (font_seg)
  );

  // Slot 0 of every digit period is dark to hide ghosting while switching anodes
  always_ff @(posedge clk) begin
    if (reset || slot == '0) begin
      an  <= '1;
      seg <= SEG_BLANK;
    end else begin
      an  <= ~(NUM_DIGITS'(1) << digit);
      seg <= font_seg;
    end
  end

  assign dp = 1'b1;

endmodule

`default_nettype wire

// File: tb/tb_scroll_display_driver.sv
// tb_scroll_display_driver -- self-checking bench for scroll_display_driver.
// Rev 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_scroll_display_driver;

  localparam int ND = 4;
  localparam int ML = 8;
  localparam int RD = 4;
  localparam int DC = 3;
  localparam int AD = 20;

  logic          clk = 1'b0;
  logic          reset;
  logic          button;
  logic          auto_en;
  logic          dir;
  logic [4*ML-1:0] msg;
  logic [ND-1:0] an;
  logic [6:0]    seg;
  logic          dp;
  logic [2:0]    pos;

  int checks = 0;
  int errors = 0;

  logic [6:0] font [16];

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic [2:0] pos;
    bit         chk_an;
    bit         chk_seg;
    bit         chk_pos;
  } exp_t;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    bit         chk_seg;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[16];

  always #5 clk = ~clk;

  scroll_display_driver #(
    .NUM_DIGITS   (ND),
    .MSG_LEN      (ML),
    .REFRESH_DIV  (RD),
    .DEBOUNCE_CYC (DC),
    .AUTO_DIV     (AD)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .button  (button),
    .auto_en (auto_en),
    .dir     (dir),
    .msg     (msg),
    .an      (an),
    .seg     (seg),
    .dp      (dp),
    .pos     (pos)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_an"},  32'(an),  32'hF);
    chk({tag, "_seg"}, 32'(seg), 32'h7F);
    chk({tag, "_dp"},  32'(dp),  32'h1);
    chk({tag, "_pos"}, 32'(pos), 32'h0);
  endtask

  // Push the expectation as the cycle is driven, pop it once the DUT has clocked
  task automatic run_expect(input string name, input exp_t e);
    exp_t got;
    sb_q.push_back(e);
    tick();
    got = sb_q.pop_front();
    if (got.chk_an)  chk({name, "_an"},  32'(an),  32'(got.an));
    if (got.chk_seg) chk({name, "_seg"}, 32'(seg), 32'(got.seg));
    if (got.chk_pos) chk({name, "_pos"}, 32'(pos), 32'(got.pos));
  endtask

  task automatic expect_pos(input string name, input int p);
    exp_t e;
    e.an = '0; e.seg = '0; e.pos = 3'(p);
    e.chk_an = 1'b0; e.chk_seg = 1'b0; e.chk_pos = 1'b1;
    run_expect(name, e);
  endtask

  task automatic do_reset();
    reset = 1'b1; button = 1'b0; auto_en = 1'b0; dir = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic press();
    button = 1'b1;
    repeat (8) tick();
    button = 1'b0;
    repeat (8) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  slot, dig;
    bit  found;
    exp_t e;

    font = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
             7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
             7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
             7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    msg = 32'h7654_3210;

    // Refresh expectations with pos=0: digit k shows char (3-k)
    for (int i = 0; i < 16; i++) begin
      slot = i % RD;
      dig  = (i / RD) % ND;
      vecs[i].an      = (slot == 0) ? 4'hF : ~(4'b0001 << dig);
      vecs[i].seg     = font[(ND - 1 - dig) % ML];
      vecs[i].chk_seg = (slot != 0);
    end

    reset = 1'b1; button = 1'b0; auto_en = 1'b0; dir = 1'b0;
    tick(); tick();
    chk_reset_state("reset");
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      e.an = vecs[i].an; e.seg = vecs[i].seg; e.pos = 3'd0;
      e.chk_an = 1'b1; e.chk_seg = vecs[i].chk_seg; e.chk_pos = 1'b1;
      run_expect($sformatf("refresh%0d", i), e);
    end

    // Short glitch is filtered
    do_reset();
    button = 1'b1;
    tick(); tick();
    button = 1'b0;
    repeat (10) tick();
    chk("glitch_pos", 32'(pos), 32'd0);

    // Held press: step lands exactly on edge 6, only once
    button = 1'b1;
    for (int k = 1; k <= 10; k++) expect_pos($sformatf("held_e%0d", k), (k >= 6) ? 1 : 0);
    button = 1'b0;
    repeat (12) tick();
    chk("release_pos", 32'(pos), 32'd1);

    // Forward wrap, then backward wrap from 0
    do_reset();
    for (int i = 0; i < ML; i++) begin
      press();
      chk($sformatf("wrap_press%0d", i), 32'(pos), 32'((i + 1) % ML));
    end
    dir = 1'b1;
    press();
    chk("back_wrap_pos", 32'(pos), 32'd7);
    dir = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 2 * ND * RD && !found; i++) begin
      tick();
      if (an == 4'b0111) found = 1'b1;
    end
    chk("leftmost_found", 32'(found), 32'd1);
    if (found) chk("leftmost_seg", 32'(seg), 32'(font[7]));

    // Auto scroll: one step every AD cycles
    do_reset();
    auto_en = 1'b1;
    for (int k = 1; k <= 100; k++) expect_pos($sformatf("auto_e%0d", k), k / AD);
    chk("auto_100_pos", 32'(pos), 32'd5);
    repeat (7) tick();
    auto_en = 1'b0;
    repeat (5) tick();
    auto_en = 1'b1;
    for (int j = 1; j <= AD; j++) expect_pos($sformatf("reenable_e%0d", j), (j == AD) ? 6 : 5);
    auto_en = 1'b0;

    // Button step and auto terminal count coincide on edge 20
    do_reset();
    auto_en = 1'b1;
    repeat (14) tick();
    button = 1'b1;
    for (int k = 15; k <= 20; k++) expect_pos($sformatf("collide_e%0d", k), (k == 20) ? 1 : 0);
    auto_en = 1'b0;
    button = 1'b0;
    repeat (12) tick();
    chk("collide_after_pos", 32'(pos), 32'd1);

    // Reset in the middle of a debounce count
    do_reset();
    button = 1'b1;
    repeat (4) tick();
    reset = 1'b1;
    button = 1'b0;
    tick();
    chk_reset_state("midrst_db");
    reset = 1'b0;
    repeat (12) tick();
    chk("midrst_db_after_pos", 32'(pos), 32'd0);

    // Reset while showing pos=6
    do_reset();
    repeat (6) press();
    chk("midrst_pre_pos", 32'(pos), 32'd6);
    reset = 1'b1;
    tick();
    chk_reset_state("midrst_pos");
    reset = 1'b0;
    repeat (12) tick();
    chk("midrst_pos_after_pos", 32'(pos), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
